// File: rtl/spu_alu_pkg.sv
// Shared opcodes, FSM state type and latency lookup for the SPU ALU issue path.
package spu_alu_pkg;

    localparam logic [5:0] OP_AH    = 6'd4;
    localparam logic [5:0] OP_AHI   = 6'd6;
    localparam logic [5:0] OP_SFH   = 6'd12;
    localparam logic [5:0] OP_MPY   = 6'd20;
    localparam logic [5:0] OP_LOG_A = 6'd28;
    localparam logic [5:0] OP_LOG_B = 6'd30;
    localparam logic [5:0] OP_IDLE  = 6'd63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Cycles the ALU needs for an opcode; zero marks an opcode the ALU does not implement.
    function automatic logic [1:0] op_latency(input logic [5:0] op);
        case (op)
            OP_AH, OP_AHI, OP_SFH, OP_LOG_A, OP_LOG_B: op_latency = 2'd1;
            OP_MPY:                                    op_latency = 2'd2;
            default:                                   op_latency = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu_zero_detect.sv
// Per-word zero flags for a four-word ALU result.
module alu_zero_detect #(
    parameter int DATA_W = 128
) (
    input  logic [DATA_W-1:0] data,
    output logic [3:0]        zero
);

    localparam int WORD_W = DATA_W / 4;

    // Flag i is set when word i of the result is all zeros.
    always_comb begin
        zero = 4'h0;
        for (int i = 0; i < 4; i++) begin
            zero[i] = (data[i*WORD_W +: WORD_W] == '0);
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and the SPU ALU: one instruction in flight,
// request held for the opcode latency, result handed to writeback.
//
//   state | meaning
//   IDLE  | ready for a new instruction, ALU sees OP_IDLE
//   EXEC  | request held on ex_*, latency timer counting down
//   RESP  | captured result offered to writeback until accepted
module alu_issue_ctrl
    import spu_alu_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int RT_W   = 7,
    parameter int CNT_W  = 32
) (
    input  logic              clk_fake,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [DATA_W-1:0] in_ra,
    input  logic [DATA_W-1:0] in_rb,
    input  logic [RT_W-1:0]   in_rt,
    output logic [5:0]        ex_opCode,
    output logic [DATA_W-1:0] ex_inA,
    output logic [DATA_W-1:0] ex_inB,
    input  logic [DATA_W-1:0] ex_dataOut,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [RT_W-1:0]   wb_rt,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        wb_zero,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic [1:0]      cnt;
    logic [1:0]      lat;
    logic [RT_W-1:0] rt_q;
    logic [3:0]      zero_next;

    assign lat = op_latency(in_op);

    alu_zero_detect #(.DATA_W(DATA_W)) u_zero_detect (
        .data (ex_dataOut),
        .zero (zero_next)
    );

    // Issue/execute/respond sequencing; every output is a register of this block.
    always_ff @(posedge clk_fake) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            rt_q        <= '0;
            in_ready    <= 1'b1;
            ex_opCode   <= OP_IDLE;
            ex_inA      <= '0;
            ex_inB      <= '0;
            wb_valid    <= 1'b0;
            wb_rt       <= '0;
            wb_data     <= '0;
            wb_zero     <= 4'h0;
            err_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (lat != 2'd0) begin
                            ex_opCode <= in_op;
                            ex_inA    <= in_ra;
                            ex_inB    <= in_rb;
                            rt_q      <= in_rt;
                            cnt       <= lat;
                            in_ready  <= 1'b0;
                            state     <= EXEC;
                        end else begin
                            // Rejected opcode never reaches the ALU.
                            err_illegal <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 2'd1) begin
                        wb_data   <= ex_dataOut;
                        wb_zero   <= zero_next;
                        wb_rt     <= rt_q;
                        wb_valid  <= 1'b1;
                        ex_opCode <= OP_IDLE;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        op_count <= op_count + CNT_ONE;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    wb_valid <= 1'b0;
                    ex_opCode <= OP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU model on the ex_* side, scoreboard of issued
// instructions, and a negedge monitor comparing every cycle against it.
module tb_alu_issue_ctrl;

    logic         clk_fake = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   in_op = 6'd0;
    logic [127:0] in_ra = '0;
    logic [127:0] in_rb = '0;
    logic [6:0]   in_rt = '0;
    logic [5:0]   ex_opCode;
    logic [127:0] ex_inA;
    logic [127:0] ex_inB;
    logic [127:0] ex_dataOut = '0;
    logic         wb_valid;
    logic         wb_ready = 1'b1;
    logic [6:0]   wb_rt;
    logic [127:0] wb_data;
    logic [3:0]   wb_zero;
    logic         err_illegal;
    logic [31:0]  op_count;

    alu_issue_ctrl dut (
        .clk_fake    (clk_fake),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_ra       (in_ra),
        .in_rb       (in_rb),
        .in_rt       (in_rt),
        .ex_opCode   (ex_opCode),
        .ex_inA      (ex_inA),
        .ex_inB      (ex_inB),
        .ex_dataOut  (ex_dataOut),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rt       (wb_rt),
        .wb_data     (wb_data),
        .wb_zero     (wb_zero),
        .err_illegal (err_illegal),
        .op_count    (op_count)
    );

    always #5 clk_fake = ~clk_fake;

    typedef struct {
        logic [5:0]   op;
        logic [127:0] ra;
        logic [127:0] rb;
        logic [127:0] data;
        logic [6:0]   rt;
        logic [3:0]   zero;
        int           acc;
        int           lat;
        bit           illegal;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    int    exp_count = 0;
    int    bp_mode = 0;
    bit    hang = 1'b0;
    bit    hang_seen = 1'b0;
    bit    done = 1'b0;
    bit    done_seen = 1'b0;
    bit    rst_prev = 1'b1;

    // ---------------- reference behaviour ----------------
    function automatic int lat_of(input logic [5:0] op);
        case (op)
            6'd4, 6'd6, 6'd12, 6'd28, 6'd30: return 1;
            6'd20:                           return 2;
            default:                         return 0;
        endcase
    endfunction

    function automatic logic [127:0] alu_f(input logic [5:0] op, input logic [127:0] a,
                                           input logic [127:0] b);
        logic [127:0] r;
        int pa;
        int pb;
        r = '0;
        case (op)
            6'd4:  for (int i = 0; i < 8; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
            6'd6:  for (int i = 0; i < 8; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[15:0];
            6'd12: for (int i = 0; i < 8; i++) r[i*16 +: 16] = b[i*16 +: 16] - a[i*16 +: 16];
            6'd20: for (int w = 0; w < 4; w++) begin
                pa = $signed(a[w*32 +: 16]);
                pb = $signed(b[w*32 +: 16]);
                r[w*32 +: 32] = pa * pb;
            end
            6'd28: r = a & b;
            6'd30: r = a | b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] zero_f(input logic [127:0] d);
        logic [3:0] z;
        for (int w = 0; w < 4; w++) z[w] = (d[w*32 +: 32] == 32'd0);
        return z;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ALU stand-in: samples the request on the falling edge.
    always @(negedge clk_fake) ex_dataOut <= alu_f(ex_opCode, ex_inA, ex_inB);

    always @(posedge clk_fake) cyc <= cyc + 1;

    always begin
        @(posedge clk_fake);
        #1;
        case (bp_mode)
            0:       wb_ready = 1'b1;
            1:       wb_ready = $urandom_range(0, 1) == 1;
            default: wb_ready = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_fake) begin
        item_t h;
        if (rst_prev) begin
            chk("rst_ex_opCode", ex_opCode, 6'd63);
            chk("rst_ex_inA", ex_inA, '0);
            chk("rst_ex_inB", ex_inB, '0);
            chk("rst_in_ready", in_ready, 1'b1);
            chk("rst_wb_valid", wb_valid, 1'b0);
            chk("rst_err_illegal", err_illegal, 1'b0);
            chk("rst_op_count", op_count, 32'd0);
            chk("rst_wb_data", wb_data, '0);
            chk("rst_wb_zero", wb_zero, 4'h0);
            chk("rst_wb_rt", wb_rt, 7'd0);
        end else if (q.size() > 0 && q[0].acc <= cyc) begin
            h = q[0];
            if (h.illegal) begin
                chk("illegal_err", err_illegal, 1'b1);
                chk("illegal_ex_opCode", ex_opCode, 6'd63);
                chk("illegal_wb_valid", wb_valid, 1'b0);
                chk("illegal_in_ready", in_ready, 1'b1);
                void'(q.pop_front());
            end else if (cyc < h.acc + h.lat) begin
                chk("exec_ex_opCode", ex_opCode, h.op);
                chk("exec_ex_inA", ex_inA, h.ra);
                chk("exec_ex_inB", ex_inB, h.rb);
                chk("exec_in_ready", in_ready, 1'b0);
                chk("exec_wb_valid", wb_valid, 1'b0);
                chk("exec_err", err_illegal, 1'b0);
            end else begin
                chk("resp_wb_valid", wb_valid, 1'b1);
                chk("resp_wb_data", wb_data, h.data);
                chk("resp_wb_zero", wb_zero, h.zero);
                chk("resp_wb_rt", wb_rt, h.rt);
                chk("resp_ex_opCode", ex_opCode, 6'd63);
                chk("resp_in_ready", in_ready, 1'b0);
                chk("resp_op_count", op_count, exp_count);
                if (wb_ready) begin
                    void'(q.pop_front());
                    exp_count++;
                end
            end
        end else begin
            chk("idle_in_ready", in_ready, 1'b1);
            chk("idle_wb_valid", wb_valid, 1'b0);
            chk("idle_err", err_illegal, 1'b0);
            chk("idle_ex_opCode", ex_opCode, 6'd63);
            chk("idle_op_count", op_count, exp_count);
        end
        if (hang && !hang_seen) begin
            hang_seen = 1'b1;
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        if (done && !done_seen) begin
            done_seen = 1'b1;
            chk("queue_drained", q.size(), 0);
        end
        if (rst) begin
            q.delete();
            exp_count = 0;
        end
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    // Garbage on the request side while the controller is busy; must be ignored.
    task automatic junk();
        in_valid = 1'b1;
        in_op    = 6'($urandom_range(0, 63));
        in_ra    = rand128();
        in_rb    = rand128();
        in_rt    = 7'($urandom_range(0, 127));
    endtask

    task automatic tick();
        @(posedge clk_fake);
        #1;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            junk();
            tick();
            w++;
        end
        in_valid = 1'b0;
        if (w >= 50) hang = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (in_ready !== 1'b1) junk();
            else in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [5:0] op, input logic [127:0] ra, input logic [127:0] rb,
                        input logic [6:0] rt);
        item_t e;
        wait_idle();
        if (hang) return;
        in_valid = 1'b1;
        in_op    = op;
        in_ra    = ra;
        in_rb    = rb;
        in_rt    = rt;
        e.op      = op;
        e.ra      = ra;
        e.rb      = rb;
        e.rt      = rt;
        e.lat     = lat_of(op);
        e.illegal = (e.lat == 0);
        e.data    = alu_f(op, ra, rb);
        e.zero    = zero_f(e.data);
        e.acc     = cyc + 1;
        q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [5:0]   legal [6] = '{6'd4, 6'd6, 6'd12, 6'd20, 6'd28, 6'd30};
        logic [5:0]   op;
        logic [127:0] ra;
        logic [127:0] rb;

        repeat (3) @(posedge clk_fake);
        #1;
        rst = 1'b0;

        send(6'd4, {8{16'h0001}}, {8{16'h0002}}, 7'd5);
        wait_idle();
        send(6'd20, {8{16'h0003}}, {8{16'h0004}}, 7'd9);
        wait_idle();
        send(6'd12, {8{16'h1234}}, {8{16'h1234}}, 7'd17);
        wait_idle();

        bp_mode = 2;
        send(6'd30, 128'h0123_4567_89ab_cdef_0000_0000_f0f0_0f0f, 128'h1, 7'd33);
        wait_cycles(7);
        bp_mode = 0;
        wait_idle();

        send(6'd9, rand128(), rand128(), 7'd44);
        wait_cycles(2);

        send(6'd20, {8{16'h0003}}, {8{16'h0004}}, 7'd50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(6'd4, {8{16'h0010}}, {8{16'h0020}}, 7'd51);
        wait_idle();

        bp_mode = 1;
        for (int n = 0; n < 150 && !hang; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else op = legal[$urandom_range(0, 5)];
            ra = rand128();
            rb = rand128();
            for (int w = 0; w < 4; w++) begin
                if ($urandom_range(0, 3) == 0) ra[w*32 +: 32] = 32'd0;
            end
            if ($urandom_range(0, 2) == 0) rb = ra;
            send(op, ra, rb, 7'($urandom_range(0, 127)));
        end
        bp_mode = 0;
        wait_idle();
        wait_cycles(3);
        done = 1'b1;
        wait_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
